// File: rtl/dmem_arbiter.sv
// Round-robin two-port (core/dma) access controller for a single-ported synchronous data memory.
// Latency: req seen in cycle 0, gnt in cycle 1, rvalid with formatted data in cycle 2; one access per 3 cycles.
// Backpressure: a requester holds req and fields stable until its gnt; the losing port is served in the next window.
module dmem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_size,
    input  logic              c_unsigned,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [3:0]        mem_we,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state, state_nx;
    logic              owner;      // 0 = core, 1 = dma
    logic              prio_dma;   // 1 = dma wins a tie next time
    logic              l_we, l_uns;
    logic [1:0]        l_size;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;

    logic              pick_d;
    logic [1:0]        off;
    logic              bad;
    logic [3:0]        lanes;
    logic [31:0]       din;
    logic [31:0]       lane;
    logic [31:0]       fmt;
    logic [31:0]       rd;
    logic              issue, resp;

    // dma wins if it is the only requester or it holds priority
    assign pick_d = d_req && (!c_req || prio_dma);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: fixed three-cycle walk once a request is accepted
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (c_req || d_req) state_nx = ISSUE;
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the winner's fields and hand priority to the other port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= 1'b0;
            prio_dma <= 1'b0;
            l_we     <= 1'b0;
            l_uns    <= 1'b0;
            l_size   <= 2'b00;
            l_addr   <= '0;
            l_wdata  <= 32'h0;
        end else if (state == IDLE && (c_req || d_req)) begin
            owner    <= pick_d;
            prio_dma <= !pick_d;
            l_we     <= pick_d ? d_we       : c_we;
            l_uns    <= pick_d ? d_unsigned : c_unsigned;
            l_size   <= pick_d ? d_size     : c_size;
            l_addr   <= pick_d ? d_addr     : c_addr;
            l_wdata  <= pick_d ? d_wdata    : c_wdata;
        end
    end

    // Alignment check, byte lanes, store replication and load extraction/extension
    always_comb begin
        off   = l_addr[1:0];
        bad   = 1'b0;
        lanes = 4'b0000;
        din   = l_wdata;
        lane  = mem_dout >> {off, 3'b000};
        fmt   = lane;
        case (l_size)
            2'b00: begin
                lanes = 4'b0001 << off;
                din   = {4{l_wdata[7:0]}};
                fmt   = l_uns ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            end
            2'b01: begin
                bad   = l_addr[0];
                lanes = 4'b0011 << off;
                din   = {2{l_wdata[15:0]}};
                fmt   = l_uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            end
            2'b10: begin
                bad   = (off != 2'b00);
                lanes = 4'b1111;
            end
            default: bad = 1'b1;
        endcase
    end

    assign issue = (state == ISSUE);
    assign resp  = (state == RESP);
    assign rd    = (l_we || bad) ? 32'h0 : fmt;

    // Memory side: address/data follow the latched request; enables only during a legal store issue
    assign mem_addr = l_addr;
    assign mem_din  = din;
    assign mem_we   = (issue && l_we && !bad) ? lanes : 4'b0000;

    // Per-port responses gated by ownership so the idle port always sees zeros
    assign c_gnt    = issue && !owner;
    assign d_gnt    = issue && owner;
    assign c_rvalid = resp && !owner;
    assign d_rvalid = resp && owner;
    assign c_err    = resp && !owner && bad;
    assign d_err    = resp && owner && bad;
    assign c_rdata  = (resp && !owner) ? rd : 32'h0;
    assign d_rdata  = (resp && owner) ? rd : 32'h0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port access controller in front of the single-ported data memory. It arbitrates between the core load/store unit (port `c_`) and the debug/DMA port (port `d_`) using round-robin. For the granted request it generates the 4-bit byte write enables and lane-replicated write data, and issues the access. It then formats the synchronous read data (byte/half/word, sign or zero extension) into a response. It sits between the pipeline MEM stage and the data memory; the memory itself is unchanged.

## Interface
- `ADDR_W`, 32, request/memory address width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `c_req` / `d_req`  in  1  request valid; held with fields stable until matching `gnt`
- `c_we` / `d_we`  in  1  1 = store, 0 = load
- `c_size` / `d_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `c_unsigned` / `d_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend
- `c_addr` / `d_addr`  in  ADDR_W  byte address
- `c_wdata` / `d_wdata`  in  32  store data, right-aligned
- `c_gnt` / `d_gnt`  out  1  one-cycle pulse: request accepted
- `c_rvalid` / `d_rvalid`  out  1  one-cycle response pulse (loads and stores)
- `c_rdata` / `d_rdata`  out  32  formatted load data; 0 for stores/errors
- `c_err` / `d_err`  out  1  valid with `rvalid`: misaligned or illegal size
- `mem_addr`  out  ADDR_W  to memory address
- `mem_din`  out  32  to memory write data
- `mem_we`  out  4  byte write enables
- `mem_dout`  in  32  memory read data, valid the cycle after the address is presented

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any `req`, latch the winner's fields and owner, then go to ISSUE.
- Both requesting: grant the port not served last; priority flag resets to core.
- ISSUE: assert the owner's `gnt`.
  - Legal access: drive `mem_addr` = latched address; stores drive `mem_we`/`mem_din`.
  - Error access: `mem_we` = 0.
  - Always go to RESP.
- RESP: pulse the owner's `rvalid`; `rdata`/`err` valid this cycle only; go to IDLE.
- Lane rules, with off = addr[1:0]:
  - byte: `mem_we` = 0001<<off, `mem_din` = {4{wdata[7:0]}}.
  - half: `mem_we` = 0011<<off, `mem_din` = {2{wdata[15:0]}}.
  - word: `mem_we` = 1111, `mem_din` = wdata.
- Load format: lane = `mem_dout` >> (8*off).
  - byte: low 8 bits; half: low 16 bits; word: as-is.
  - Extend per `unsigned`.
- Errors: half with addr[0]=1, word with off≠0, or size=11.
  - No memory write; `err`=1, `rdata`=0.
- Stores: `rvalid`=1, `rdata`=0.
- Non-owner outputs are 0 at all times.
- `mem_addr`/`mem_din` hold the latched values outside ISSUE; `mem_we` = 0 outside ISSUE.

## Timing
- Reset values: state IDLE, priority = core, latched fields 0, all outputs 0 (including `mem_we`).
- Reset is asynchronous: asserting it in ISSUE forces `mem_we` to 0 immediately, and the in-flight access is dropped with no `rvalid`.
- Latency: `req` seen in cycle 0 → `gnt` in cycle 1 (memory samples at end of cycle 1) → `rvalid` in cycle 2. The next request is accepted in cycle 3 at the earliest.
- Throughput: one access per 3 cycles.
- Requester drops `req` the cycle after `gnt`. A `req` still high in IDLE is a new request.
- Simultaneous requests: the loser keeps `req` high and is served next (after the 3-cycle window), even if the winner re-requests.
- `req` changes outside IDLE are ignored.

## Test plan
- Reset then core word store addr 0x10 data 0xDEADBEEF, then load → `c_gnt` cycle 1, `mem_we`=1111; load `c_rdata`=0xDEADBEEF in cycle 2 of its access.
- Byte store 0x5A to 0x13 over word 0 → `mem_we`=1000, `mem_din`=0x5A5A5A5A. Signed byte load 0x13 of 0x80 → 0xFFFFFF80; unsigned → 0x00000080.
- Half load at 0x12 of word 0x8001xxxx → signed 0xFFFF8001; half at 0x11 → `err`=1, `rdata`=0, no memory write.
- Both ports request every idle cycle → grants alternate core, dma, core…; a single requester is served back-to-back every 3 cycles.
- Assert `rst` during ISSUE of a store → `mem_we` drops to 0 immediately, target word unchanged, no `rvalid`, next access follows normal timing.
- Size 11 store from dma → `d_err`=1 with `d_rvalid`, `mem_we` stays 0000.
